serial_deserializer: RTL and testbench

- Single-clock 1:N serial-to-parallel converter, the receive counterpart of the design's word serializer.
- Samples one bit per `bit_en_i` strobe and assembles DATA_WIDTH-bit words, first-received bit in bit 0.
- Word boundary is adjustable by bitslip, either manually or through a built-in training-pattern alignment FSM.
- Feeds received-word consumers (e.g. loopback checkers and link-training logic) inside the fabric.

---
 rtl/serdes_pkg.sv | 21 ++
 rtl/deser_align_fsm.sv | 95 +++++++++
 rtl/serial_deserializer.sv | 99 +++++++++
 tb/tb_serial_deserializer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and width helpers for the serial deserializer.
// Holds the aligner state encoding and counter-width functions.
package serdes_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  // CNT_W helper: width of the bit-position counter.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // SLIP_W helper: width of a counter that can hold max_slips.
  function automatic int unsigned slip_w(input int unsigned m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/deser_align_fsm.sv
// Training-pattern aligner: checks each completed word, asks for slips.
// Ports: clk, rst_n, word_i, word_valid_i, realign_i -> slip_req_o, aligned_o, align_err_o.
module deser_align_fsm
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_WORD = 'h6A,
  parameter int LOCK_MATCHES = 4,
  parameter int MAX_SLIPS = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  word_valid_i,
  input  logic                  realign_i,
  output logic                  slip_req_o,
  output logic                  aligned_o,
  output logic                  align_err_o
);

  localparam int SLIP_W = slip_w(MAX_SLIPS);
  localparam logic [3:0] LOCK_N = 4'(LOCK_MATCHES);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(MAX_SLIPS - 1);

  align_state_e      state_q, state_d;
  logic [3:0]        match_q, match_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic              err_q, err_d;
  logic              hit;

  assign hit = (word_i == TRAIN_WORD);

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    slip_d     = slip_q;
    err_d      = err_q;
    slip_req_o = 1'b0;
    // realign outranks a word evaluated in the same cycle
    if (realign_i) begin
      state_d = HUNT;
      match_d = '0;
      slip_d  = '0;
      err_d   = 1'b0;
    end else if (word_valid_i) begin
      unique case (1'b1)
        (state_q == HUNT): begin
          if (hit) begin
            match_d = 4'd1;
            state_d = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
          end else begin
            slip_req_o = 1'b1;
            if (slip_q == SLIP_LAST) begin
              slip_d = '0;
              err_d  = 1'b1;
            end else begin
              slip_d = slip_q + SLIP_W'(1);
            end
          end
        end
        (state_q == VERIFY): begin
          if (hit) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            state_d    = HUNT;
            match_d    = '0;
            slip_req_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      match_q <= '0;
      slip_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      slip_q  <= slip_d;
      err_q   <= err_d;
    end
  end

  assign aligned_o   = (state_q == LOCKED);
  assign align_err_o = err_q;

endmodule

// File: rtl/serial_deserializer.sv
// 1:N serial-to-parallel converter with bitslip and auto alignment.
// Ports: clk, rst_n, bit_en_i, bit_i, bitslip_i, realign_i -> word_o, word_valid_o, aligned_o, align_err_o.
module serial_deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_WORD = 'h6A,
  parameter int LOCK_MATCHES = 4,
  parameter int MAX_SLIPS = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_en_i,
  input  logic                  bit_i,
  input  logic                  bitslip_i,
  input  logic                  realign_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_valid_o,
  output logic                  aligned_o,
  output logic                  align_err_o
);

  localparam int CNT_W = cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic                  fsm_slip;
  logic                  slip_req;
  logic                  slip_now;
  logic [DATA_WIDTH-1:0] shifted;

  // manual and aligner requests merge into one slip
  assign slip_req = bitslip_i | fsm_slip;
  assign slip_now = bit_en_i & (pend_q | slip_req);
  assign shifted  = {bit_i, sr_q[DATA_WIDTH-1:1]};

  always_comb begin
    sr_d    = sr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    valid_d = 1'b0;
    if (bit_en_i) begin
      sr_d = shifted;
      // a slipped bit enters sr but does not advance the word position
      if (slip_now) begin
        pend_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      pend_d = pend_q | slip_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  deser_align_fsm #(
    .DATA_WIDTH   (DATA_WIDTH),
    .TRAIN_WORD   (TRAIN_WORD),
    .LOCK_MATCHES (LOCK_MATCHES),
    .MAX_SLIPS    (MAX_SLIPS)
  ) u_align (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_i       (word_q),
    .word_valid_i (valid_q),
    .realign_i    (realign_i),
    .slip_req_o   (fsm_slip),
    .aligned_o    (aligned_o),
    .align_err_o  (align_err_o)
  );

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (W=8, TRAIN_WORD=0x6A).
// Inputs change on negedge; outputs are read on the following negedge.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       bit_in = 1'b0;
  logic       slip = 1'b0;
  logic       realign = 1'b0;
  logic [7:0] word;
  logic       valid;
  logic       aligned;
  logic       err;

  int total = 0;
  int bad = 0;

  serial_deserializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_en_i     (bit_en),
    .bit_i        (bit_in),
    .bitslip_i    (slip),
    .realign_i    (realign),
    .word_o       (word),
    .word_valid_o (valid),
    .aligned_o    (aligned),
    .align_err_o  (err)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic en, input logic b,
                      input logic sl, input logic re);
    bit_en  = en;
    bit_in  = b;
    slip    = sl;
    realign = re;
    @(negedge clk);
  endtask

  task automatic do_reset;
    bit_en  = 1'b0;
    bit_in  = 1'b0;
    slip    = 1'b0;
    realign = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({word, valid, aligned, err} !== 11'h0) begin
      bad++;
      $display("FAIL rst_hold got %h exp 000",
               {word, valid, aligned, err});
    end
    rst_n = 1'b1;
    repeat (20) tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (word !== 8'h00) begin
      bad++;
      $display("FAIL idle_word got %h exp 00", word);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_valid got %b exp 0", valid);
    end
    total++;
    if (aligned !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL idle_flags got %b%b exp 00", aligned, err);
    end
  endtask

  // realign held high so the aligner never evaluates these words
  task automatic test_basic;
    logic [7:0] pat [2];
    int         stamp [4];
    logic [7:0] wv [4];
    int         nv;
    int         cyc;
    pat[0] = 8'hA5;
    pat[1] = 8'h3C;
    nv  = 0;
    cyc = 0;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        tick(1'b1, pat[w][i], 1'b0, 1'b1);
        cyc++;
        if (valid === 1'b1 && nv < 4) begin
          stamp[nv] = cyc;
          wv[nv]    = word;
          nv++;
        end
      end
    end
    total++;
    if (nv !== 2) begin
      bad++;
      $display("FAIL basic_count got %0d exp 2", nv);
    end
    total++;
    if (stamp[0] !== 8 || wv[0] !== 8'hA5) begin
      bad++;
      $display("FAIL basic_w0 got %0d/%h exp 8/a5",
               stamp[0], wv[0]);
    end
    total++;
    if (stamp[1] !== 16 || wv[1] !== 8'h3C) begin
      bad++;
      $display("FAIL basic_w1 got %0d/%h exp 16/3c",
               stamp[1], wv[1]);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (valid !== 1'b0 || word !== 8'h3C) begin
      bad++;
      $display("FAIL basic_hold got %b/%h exp 0/3c", valid, word);
    end
  endtask

  // stream starts 5 bits into the pattern: three slips reach phase 0
  task automatic test_auto_align;
    logic [7:0] tr;
    logic [7:0] vals [16];
    int         np;
    int         lockp;
    tr    = 8'h6A;
    np    = 0;
    lockp = -1;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      tick(1'b1, tr[3'((n + 5) % 8)], 1'b0, 1'b0);
      if (valid === 1'b1 && np < 16) begin
        vals[np] = word;
        np++;
      end
      if (aligned === 1'b1 && lockp < 0) lockp = np;
    end
    total++;
    if (np !== 9) begin
      bad++;
      $display("FAIL auto_count got %0d exp 9", np);
    end
    total++;
    if (vals[0] !== 8'h53 || vals[1] !== 8'hA9) begin
      bad++;
      $display("FAIL auto_w01 got %h %h exp 53 a9",
               vals[0], vals[1]);
    end
    total++;
    if (vals[2] !== 8'hD4 || vals[3] !== 8'h6A) begin
      bad++;
      $display("FAIL auto_w23 got %h %h exp d4 6a",
               vals[2], vals[3]);
    end
    total++;
    if (lockp !== 7) begin
      bad++;
      $display("FAIL auto_lock got %0d exp 7", lockp);
    end
    total++;
    if (vals[8] !== 8'h6A || aligned !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL auto_after got %h/%b/%b exp 6a/1/0",
               vals[8], aligned, err);
    end
  endtask

  task automatic test_error;
    int np;
    int errp;
    int anyal;
    np    = 0;
    errp  = -1;
    anyal = 0;
    do_reset();
    for (int n = 0; n < 160; n++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (valid === 1'b1) np++;
      if (err === 1'b1 && errp < 0) errp = np;
      if (aligned === 1'b1) anyal = 1;
    end
    total++;
    if (errp !== 16) begin
      bad++;
      $display("FAIL err_at got %0d exp 16", errp);
    end
    total++;
    if (np !== 17) begin
      bad++;
      $display("FAIL err_words got %0d exp 17", np);
    end
    total++;
    if (anyal !== 0 || err !== 1'b1) begin
      bad++;
      $display("FAIL err_flags got %0d/%b exp 0/1", anyal, err);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (err !== 1'b0 || aligned !== 1'b0) begin
      bad++;
      $display("FAIL err_realign got %b/%b exp 0/0", err, aligned);
    end
  endtask

  task automatic test_manual_slip;
    logic [7:0] tr;
    tr = 8'h6A;
    do_reset();
    for (int n = 0; n < 49; n++) begin
      tick(1'b1, tr[3'(n % 8)], (n == 39), 1'b0);
      if (n == 38) begin
        total++;
        if (aligned !== 1'b1) begin
          bad++;
          $display("FAIL mslip_pre got %b exp 1", aligned);
        end
      end
      if (n == 39) begin
        total++;
        if (valid !== 1'b0) begin
          bad++;
          $display("FAIL mslip_supp got %b exp 0", valid);
        end
      end
      if (n == 40) begin
        total++;
        if (valid !== 1'b1 || word !== 8'h35) begin
          bad++;
          $display("FAIL mslip_w1 got %b/%h exp 1/35", valid, word);
        end
      end
      if (n == 48) begin
        total++;
        if (valid !== 1'b1 || word !== 8'h35 || aligned !== 1'b1) begin
          bad++;
          $display("FAIL mslip_w2 got %b/%h/%b exp 1/35/1",
                   valid, word, aligned);
        end
      end
    end
  endtask

  task automatic test_gapped;
    logic [7:0] a;
    logic [7:0] c;
    int         nv;
    int         first;
    a     = 8'hA5;
    c     = 8'h3C;
    nv    = 0;
    first = -1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, a[i], 1'b0, 1'b1);
      if (valid === 1'b1) nv++;
      repeat (2) begin
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        if (valid === 1'b1) nv++;
      end
    end
    total++;
    if (nv !== 1 || word !== 8'hA5) begin
      bad++;
      $display("FAIL gap_w0 got %0d/%h exp 1/a5", nv, word);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, c[i], 1'b0, 1'b1);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (word !== 8'h00 || valid !== 1'b0) begin
      bad++;
      $display("FAIL gap_arst got %h/%b exp 00/0", word, valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, c[i], 1'b0, 1'b1);
      if (valid === 1'b1) begin
        nv++;
        if (first < 0) first = i + 1;
      end
      repeat (2) begin
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        if (valid === 1'b1) nv++;
      end
    end
    total++;
    if (first !== 8 || nv !== 1) begin
      bad++;
      $display("FAIL gap_fresh got %0d/%0d exp 8/1", first, nv);
    end
    total++;
    if (word !== 8'h3C) begin
      bad++;
      $display("FAIL gap_w1 got %h exp 3c", word);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_auto_align();
    test_error();
    test_manual_slip();
    test_gapped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
